// File: rtl/mac_result_serializer.sv
// mac_result_serializer
// Buffers 16-bit MAC results and their overflow flags in a small FIFO. Each
// result is sent as bytes over a valid/ready handshake: low byte first, then
// high byte. The sticky drop_flag records any result lost to a full FIFO.
// Optional feature macro: MAC_SER_STATUS_EN. When it is defined, a third
// status byte {ovf, drop_flag, 2'b00, count[3:0]} follows every result.
module mac_result_serializer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_ovf,
    input  logic              clr_drop,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_is_hi,
    output logic              ovf_out,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              drop_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef MAC_SER_STATUS_EN
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_ST} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;
`endif

    logic [DATA_W:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;
    logic [DATA_W:0] r_hold;
    logic            r_drop;
    state_t          r_state;
    state_t          w_nextState;
    logic            w_push;
    logic            w_pop;
`ifdef MAC_SER_STATUS_EN
    logic [7:0]      r_status;
    logic            w_loadStatus;
    logic [3:0]      w_count4;
`endif

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign fifo_full  = (r_count == CW'(DEPTH));
    assign fifo_empty = (r_count == '0);
    assign w_push     = res_valid & ~fifo_full;
    assign drop_flag  = r_drop;
    assign ovf_out    = r_hold[DATA_W];
`ifdef MAC_SER_STATUS_EN
    assign w_count4   = 4'(r_count);
`endif

    // FIFO storage; no reset is needed because the pointers and count say what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {res_ovf, res_data};
        end
    end

    // Pointers, occupancy count and the output holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
                r_hold  <= r_mem[r_rdPtr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky drop indication; a new refused push wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (res_valid && fifo_full) begin
            r_drop <= 1'b1;
        end else if (clr_drop) begin
            r_drop <= 1'b0;
        end
    end

`ifdef MAC_SER_STATUS_EN
    // Status byte is snapshotted when the high byte leaves, so it stays stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else if (w_loadStatus) begin
            r_status <= {r_hold[DATA_W], r_drop, 2'b00, w_count4};
        end
    end
`endif

    // Serializer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, pop request and byte outputs; outputs depend only on registered state.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        byte_valid  = 1'b0;
        byte_out    = 8'h00;
        byte_is_hi  = 1'b0;
`ifdef MAC_SER_STATUS_EN
        w_loadStatus = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_pop       = 1'b1;
                    w_nextState = S_LO;
                end
            end
            S_LO: begin
                byte_valid = 1'b1;
                byte_out   = r_hold[7:0];
                if (byte_ready) begin
                    w_nextState = S_HI;
                end
            end
            S_HI: begin
                byte_valid = 1'b1;
                byte_out   = r_hold[15:8];
                byte_is_hi = 1'b1;
                if (byte_ready) begin
`ifdef MAC_SER_STATUS_EN
                    w_loadStatus = 1'b1;
                    w_nextState  = S_ST;
`else
                    if (!fifo_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = S_LO;
                    end else begin
                        w_nextState = S_IDLE;
                    end
`endif
                end
            end
`ifdef MAC_SER_STATUS_EN
            S_ST: begin
                byte_valid = 1'b1;
                byte_out   = r_status;
                byte_is_hi = 1'b1;
                if (byte_ready) begin
                    if (!fifo_empty) begin
                        w_pop       = 1'b1;
                        w_nextState = S_LO;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_result_serializer.sv
// tb_mac_result_serializer
// Directed bench with a scoreboard of pushed results. A negedge monitor checks
// every transferred byte against the scoreboard and checks that stalled
// outputs hold steady. Honours MAC_SER_STATUS_EN (three bytes per result).
module tb_mac_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        clr_drop;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_is_hi;
    logic        ovf_out;
    logic        fifo_full;
    logic        fifo_empty;
    logic        drop_flag;

`ifdef MAC_SER_STATUS_EN
    localparam int BYTES_PER = 3;
`else
    localparam int BYTES_PER = 2;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic        ovf;
    } res_t;

    res_t       sbQueue[$];
    int         errors = 0;
    int         checks = 0;
    int         byteIdx = 0;
    logic       pendValid = 1'b0;
    logic [9:0] pendVals = '0;

    mac_result_serializer #(.DEPTH(4), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ovf    (res_ovf),
        .clr_drop   (clr_drop),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_is_hi (byte_is_hi),
        .ovf_out    (ovf_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .drop_flag  (drop_flag)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] data, input logic ovf, input bit expectAccept);
        res_valid = 1'b1;
        res_data  = data;
        res_ovf   = ovf;
        if (expectAccept) sbQueue.push_back('{data: data, ovf: ovf});
        tick();
        res_valid = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (!(fifo_empty && !byte_valid) && n < 200) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(n < 200), 32'd1);
        checkOutput({tag, "_sb_drained"}, 32'(sbQueue.size()), 32'd0);
    endtask

    // Scoreboard monitor: compares every transferred byte and checks stall stability.
    always @(negedge clk) begin
        res_t       head;
        logic [7:0] expByte;
        if (rst) begin
            byteIdx   = 0;
            pendValid = 1'b0;
        end else begin
            if (pendValid) begin
                checkOutput("stall_valid", byte_valid, 1);
                checkOutput("stall_stable", {byte_out, byte_is_hi, ovf_out}, pendVals);
            end
            if (byte_valid && byte_ready) begin
                checkOutput("sb_has_entry", 32'(sbQueue.size() != 0), 32'd1);
                if (sbQueue.size() != 0) begin
                    head = sbQueue[0];
                    checkOutput("xfer_ovf", ovf_out, head.ovf);
                    if (byteIdx == 0) begin
                        expByte = head.data[7:0];
                        checkOutput("xfer_lo", {byte_out, byte_is_hi}, {expByte, 1'b0});
                    end else if (byteIdx == 1) begin
                        expByte = head.data[15:8];
                        checkOutput("xfer_hi", {byte_out, byte_is_hi}, {expByte, 1'b1});
                    end else begin
                        checkOutput("xfer_status", {byte_out[7], byte_out[5:4], byte_is_hi},
                                    {head.ovf, 2'b00, 1'b1});
                    end
                    byteIdx++;
                    if (byteIdx == BYTES_PER) begin
                        void'(sbQueue.pop_front());
                        byteIdx = 0;
                    end
                end
                pendValid = 1'b0;
            end else if (byte_valid) begin
                pendValid = 1'b1;
                pendVals  = {byte_out, byte_is_hi, ovf_out};
            end else begin
                pendValid = 1'b0;
            end
        end
    end

    initial begin
        int gaps;
        int seen;
        rst        = 1'b1;
        res_valid  = 1'b0;
        res_data   = '0;
        res_ovf    = 1'b0;
        clr_drop   = 1'b0;
        byte_ready = 1'b0;
        #2;
        checkOutput("rst_valid", byte_valid, 0);
        checkOutput("rst_byte", byte_out, 0);
        checkOutput("rst_hi", byte_is_hi, 0);
        checkOutput("rst_ovf", ovf_out, 0);
        checkOutput("rst_empty", fifo_empty, 1);
        checkOutput("rst_full", fifo_full, 0);
        checkOutput("rst_drop", drop_flag, 0);
        tick();
        tick();
        rst = 1'b0;

        // Test 1: single result, latency and byte order.
        byte_ready = 1'b1;
        applyStimulus(16'h1234, 1'b0, 1'b1);
        checkOutput("t1_valid_at_push", byte_valid, 0);
        tick();
        checkOutput("t1_valid_next", byte_valid, 1);
        checkOutput("t1_lo", {byte_out, byte_is_hi}, {8'h34, 1'b0});
        tick();
        checkOutput("t1_hi", {byte_out, byte_is_hi}, {8'h12, 1'b1});
        waitIdle("t1");

        // Test 2: stall on the low byte, then release.
        byte_ready = 1'b0;
        applyStimulus(16'hBEEF, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_stall_byte", byte_out, 8'hEF);
            checkOutput("t2_stall_ovf", ovf_out, 1);
            tick();
        end
        byte_ready = 1'b1;
        tick();
        checkOutput("t2_hi", {byte_out, ovf_out}, {8'hBE, 1'b1});
        waitIdle("t2");

        // Test 3: overflow the FIFO, drain in order, then clear the drop flag.
        byte_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'hA000 + 16'(i), 1'(i & 1), i < 5);
        end
        checkOutput("t3_full", fifo_full, 1);
        checkOutput("t3_drop_set", drop_flag, 1);
        byte_ready = 1'b1;
        waitIdle("t3");
        checkOutput("t3_drop_sticky", drop_flag, 1);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        checkOutput("t3_drop_clr", drop_flag, 0);

        // Test 4: steady stream with ready held high, no gaps, no drops.
        byte_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'h5A00 + 16'(i * 17), 1'(i >> 1), 1'b1);
            if (i > 0 && !byte_valid) gaps++;
            for (int k = 0; k < BYTES_PER - 1; k++) begin
                tick();
                if (!byte_valid) gaps++;
            end
        end
        checkOutput("t4_gaps", gaps, 0);
        checkOutput("t4_no_drop", drop_flag, 0);
        waitIdle("t4");

        // Test 5: reset while sending the high byte with three results queued.
        byte_ready = 1'b0;
        applyStimulus(16'h1111, 1'b1, 1'b1);
        applyStimulus(16'h2222, 1'b0, 1'b1);
        applyStimulus(16'h3333, 1'b0, 1'b1);
        applyStimulus(16'h4444, 1'b0, 1'b1);
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        checkOutput("t5_in_hi", {byte_valid, byte_is_hi, byte_out}, {2'b11, 8'h11});
        checkOutput("t5_queued_not_empty", fifo_empty, 0);
        #2;
        rst = 1'b1;
        sbQueue.delete();
        #1;
        checkOutput("t5_rst_valid", byte_valid, 0);
        checkOutput("t5_rst_byte", byte_out, 0);
        checkOutput("t5_rst_hi", byte_is_hi, 0);
        checkOutput("t5_rst_ovf", ovf_out, 0);
        checkOutput("t5_rst_empty", fifo_empty, 1);
        tick();
        rst = 1'b0;
        byte_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (byte_valid) seen++;
        end
        checkOutput("t5_no_bytes_after", seen, 0);
        checkOutput("t5_empty_after", fifo_empty, 1);

`ifdef MAC_SER_STATUS_EN
        // Test 6: status byte after a lone result.
        byte_ready = 1'b0;
        applyStimulus(16'h00FF, 1'b1, 1'b1);
        tick();
        byte_ready = 1'b1;
        checkOutput("t6_lo", byte_out, 8'hFF);
        tick();
        checkOutput("t6_hi", byte_out, 8'h00);
        tick();
        checkOutput("t6_status", {byte_out, byte_is_hi}, {8'h80, 1'b1});
        waitIdle("t6");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
